// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by the APB master, the APB slave and the benches.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-phase wait counter; flags the last permitted wait cycle.
// With TIMEOUT == 0 the timeout is disabled and expired stays low.
module apb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: turns one local read/write command into a SETUP/ACCESS
// transfer and returns a single-cycle response with read data and error flag.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state, state_next;
  logic       accept;
  logic       complete;
  logic       abort;
  logic       expired;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state == ACCESS) && pready;
  // pready wins over a simultaneous timeout.
  assign abort     = (state == ACCESS) && !pready && expired;

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      ((state == ACCESS) && !pready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: assigning state_next before the case keeps every path driven,
  // so no latch is inferred for unlisted transitions.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (complete || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // APB strobes follow the next state so they are registered yet cycle-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      psel      <= (state_next != IDLE);
      penable   <= (state_next == ACCESS);
      rsp_valid <= 1'b0;

      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end

      if (complete) begin
        rsp_valid <= 1'b1;
        rsp_err   <= pslverr;
        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
      end else if (abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): the bench plays the APB slave and
// checks strobes, captured address/data and response timing cycle by cycle.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int compared   = 0;
  int mismatched = 0;

  apb_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are stable and inputs set here are
  // sampled at the following rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    step(); step();
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
    compared++; if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin mismatched++; $display("FAIL rst_ctrl got=%05b exp=00000", {psel, penable, pwrite, rsp_valid, rsp_err}); end
    compared++; if ({paddr, pwdata, rsp_rdata} !== 24'h0) begin mismatched++; $display("FAIL rst_data got=%06h exp=000000", {paddr, pwdata, rsp_rdata}); end
    rst = 1'b0;
    step();
    compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release_ready got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    // cycle T
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'hA5;
    pready = 1'b1; pslverr = 1'b0; prdata = 8'hEE;
    step(); // T+1 SETUP
    cmd_valid = 1'b0;
    compared++; if ({psel, penable} !== 2'b10) begin mismatched++; $display("FAIL wr_setup got=%02b exp=10", {psel, penable}); end
    compared++; if ({pwrite, paddr, pwdata} !== {1'b1, 8'h01, 8'hA5}) begin mismatched++; $display("FAIL wr_capture got=%0b/%02h/%02h exp=1/01/a5", pwrite, paddr, pwdata); end
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL wr_busy_ready got=%0b exp=0", cmd_ready); end
    step(); // T+2 ACCESS
    compared++; if ({psel, penable, rsp_valid} !== 3'b110) begin mismatched++; $display("FAIL wr_access got=%03b exp=110", {psel, penable, rsp_valid}); end
    step(); // T+3 response
    compared++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin mismatched++; $display("FAIL wr_rsp got=%0b/%0b/%02h exp=1/0/00", rsp_valid, rsp_err, rsp_rdata); end
    compared++; if ({psel, penable, cmd_ready} !== 3'b001) begin mismatched++; $display("FAIL wr_done got=%03b exp=001", {psel, penable, cmd_ready}); end
    compared++; if ({paddr, pwdata} !== {8'h01, 8'hA5}) begin mismatched++; $display("FAIL wr_idle_hold got=%02h/%02h exp=01/a5", paddr, pwdata); end
    step();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL wr_rsp_pulse got=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_read_wait();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h12; cmd_wdata = 8'h00;
    pready = 1'b0; prdata = 8'h00;
    step(); // T+1 SETUP
    cmd_valid = 1'b0;
    step(); // T+2 ACCESS, wait 1
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin pready = 1'b1; prdata = 8'h3C; end
      compared++; if ({psel, penable, pwrite, paddr, rsp_valid} !== {3'b110, 8'h12, 1'b0}) begin mismatched++; $display("FAIL rd_wait_access%0d got=%0b%0b%0b/%02h/%0b exp=110/12/0", i, psel, penable, pwrite, paddr, rsp_valid); end
      step();
    end
    // T+5
    compared++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h3C}) begin mismatched++; $display("FAIL rd_wait_rsp got=%0b/%0b/%02h exp=1/0/3c", rsp_valid, rsp_err, rsp_rdata); end
    compared++; if ({psel, penable} !== 2'b00) begin mismatched++; $display("FAIL rd_wait_idle got=%02b exp=00", {psel, penable}); end
    step();
  endtask

  task automatic test_slave_error();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
    pready = 1'b1; pslverr = 1'b1; prdata = 8'h77;
    step(); cmd_valid = 1'b0;
    step();
    step(); // T+3
    compared++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 8'h00}) begin mismatched++; $display("FAIL err_rsp got=%0b/%0b/%02h exp=1/1/00", rsp_valid, rsp_err, rsp_rdata); end
    compared++; if ({psel, cmd_ready} !== 2'b01) begin mismatched++; $display("FAIL err_idle got=%02b exp=01", {psel, cmd_ready}); end
    pslverr = 1'b0;
    step();
    compared++; if ({rsp_valid, rsp_err} !== 2'b01) begin mismatched++; $display("FAIL err_hold got=%02b exp=01", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
    pready = 1'b0; prdata = 8'hFF;
    step(); cmd_valid = 1'b0; // T+1
    step(); step(); step(); step(); // T+5: fourth ACCESS cycle
    compared++; if ({psel, penable, rsp_valid} !== 3'b110) begin mismatched++; $display("FAIL to_last_access got=%03b exp=110", {psel, penable, rsp_valid}); end
    step(); // T+6
    compared++; if ({psel, penable} !== 2'b00) begin mismatched++; $display("FAIL to_idle got=%02b exp=00", {psel, penable}); end
    compared++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 8'h00}) begin mismatched++; $display("FAIL to_rsp got=%0b/%0b/%02h exp=1/1/00", rsp_valid, rsp_err, rsp_rdata); end
    // Follow-up command completes normally.
    cmd_valid = 1'b1; cmd_addr = 8'h21; pready = 1'b1; prdata = 8'h5A;
    step(); cmd_valid = 1'b0;
    step(); step();
    compared++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h5A}) begin mismatched++; $display("FAIL to_recover got=%0b/%0b/%02h exp=1/0/5a", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  task automatic test_timeout_race();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22;
    pready = 1'b0; prdata = 8'h00;
    step(); cmd_valid = 1'b0;
    step(); step(); step(); // T+4
    step(); // T+5: last permitted wait, slave answers now
    pready = 1'b1; prdata = 8'h99;
    step(); // T+6
    compared++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h99}) begin mismatched++; $display("FAIL race_rsp got=%0b/%0b/%02h exp=1/0/99", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h11;
    pready = 1'b1; pslverr = 1'b0;
    step(); // T+1: next command presented while busy
    cmd_addr = 8'h31; cmd_wdata = 8'h22;
    step(); // T+2
    compared++; if ({paddr, pwdata} !== {8'h30, 8'h11}) begin mismatched++; $display("FAIL b2b_ignore got=%02h/%02h exp=30/11", paddr, pwdata); end
    step(); // T+3: rsp cycle, second accepted here
    compared++; if ({rsp_valid, psel, cmd_ready} !== 3'b101) begin mismatched++; $display("FAIL b2b_gap got=%03b exp=101", {rsp_valid, psel, cmd_ready}); end
    step(); // T+4
    cmd_valid = 1'b0;
    compared++; if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b100, 8'h31, 8'h22}) begin mismatched++; $display("FAIL b2b_second got=%0b%0b%0b/%02h/%02h exp=100/31/22", psel, penable, rsp_valid, paddr, pwdata); end
    step(); step(); // T+6
    compared++; if ({rsp_valid, psel} !== 2'b10) begin mismatched++; $display("FAIL b2b_rsp2 got=%02b exp=10", {rsp_valid, psel}); end
    step();
    compared++; if ({rsp_valid, psel} !== 2'b00) begin mismatched++; $display("FAIL b2b_single got=%02b exp=00", {rsp_valid, psel}); end
  endtask

  task automatic test_reset_mid_access();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
    pready = 1'b0; prdata = 8'h00;
    step(); cmd_valid = 1'b0;
    step(); step(); // T+3 ACCESS wait
    compared++; if ({psel, penable} !== 2'b11) begin mismatched++; $display("FAIL rma_access got=%02b exp=11", {psel, penable}); end
    rst = 1'b1;
    step(); // T+4
    compared++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin mismatched++; $display("FAIL rma_reset got=%04b exp=0000", {psel, penable, rsp_valid, cmd_ready}); end
    compared++; if (paddr !== 8'h00) begin mismatched++; $display("FAIL rma_paddr got=%02h exp=00", paddr); end
    rst = 1'b0; pready = 1'b1;
    step();
    compared++; if ({cmd_ready, rsp_valid, psel} !== 3'b100) begin mismatched++; $display("FAIL rma_release got=%03b exp=100", {cmd_ready, rsp_valid, psel}); end
    step();
    compared++; if ({rsp_valid, psel} !== 2'b00) begin mismatched++; $display("FAIL rma_no_rsp got=%02b exp=00", {rsp_valid, psel}); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that issues single APB3 transfers on behalf of a local command port (CPU/test-sequencer side). It pairs with the APB slave used for the UART controller register file.
- Accepts one read or write command at a time and runs the SETUP/ACCESS phases with wait-state support.
- Returns a one-cycle response carrying read data and an error flag.
- A bounded timeout prevents a hung slave from locking the bus.

Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- clk  in  1  system clock; also PCLK
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR seen or timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready / wait-state
- pslverr  in  1  APB slave error

Behaviour:
- Reset:
  - state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0; timeout count = 0.
  - Reset asserted mid-transfer: psel/penable drop at that edge, the latched command is discarded, and no response is issued.
- Outputs: all APB and rsp outputs are registered. cmd_ready is combinational: (state==IDLE) && !rst.
- Handshake:
  - A command is accepted on a clock edge where cmd_valid && cmd_ready.
  - cmd_addr, cmd_write and cmd_wdata are captured into paddr, pwrite and pwdata at that edge.
  - cmd_* values are ignored while cmd_ready=0.
- FSM (IDLE, SETUP, ACCESS):
  - IDLE: psel=0, penable=0. On accept -> SETUP.
  - SETUP: psel=1, penable=0. Exactly one cycle -> ACCESS.
  - ACCESS: psel=1, penable=1. Each cycle pready is sampled.
    - pready=1: capture response, go to IDLE, psel/penable=0 next cycle.
    - pready=0: stay in ACCESS and increment the timeout count.
    - Timeout: if TIMEOUT!=0 and the count reaches TIMEOUT-1 with pready=0, abort: go to IDLE, rsp_err=1, rsp_rdata=0.
- Latency:
  - Accept edge at the end of cycle T; SETUP in T+1; ACCESS from T+2.
  - With zero wait states, rsp_valid=1 in T+3 and cmd_ready=1 in T+3.
  - Minimum 3 cycles per transfer; each wait state adds 1.
- Response:
  - rsp_valid is high for exactly one cycle.
  - rsp_err = pslverr sampled with pready, or 1 on timeout.
  - rsp_rdata = prdata for a successful read; 0 for writes or errors.
  - rsp_rdata and rsp_err hold their values until the next response; there is no backpressure on rsp.
- Stability: paddr, pwrite and pwdata stay constant from SETUP through the final ACCESS cycle and retain their values in IDLE.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - Cleared on entry to SETUP; saturates and never wraps.
- Simultaneous events:
  - pready=1 and timeout in the same cycle: pready wins, normal completion.
  - A command presented in the same cycle as rsp_valid is accepted, because state is IDLE.
- pslverr is ignored unless psel && penable && pready.

Decomposition:
- Package apb_pkg:
  - State localparams IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Default widths ADDR_W/DATA_W.
  - Shared with the APB slave and benches.
- One sub-module, apb_timeout_counter:
  - Ports: clk, rst, clr, en, expired.
  - Parameterised by TIMEOUT; ties expired to 0 when TIMEOUT==0.
- FSM and datapath stay in apb_master.

Test Plan:
- Write, zero wait: cmd write addr=0x01 wdata=0xA5 -> psel 1 in T+1, penable 1 in T+2, pwrite=1, paddr=0x01, pwdata=0xA5; rsp_valid in T+3, rsp_err=0, rsp_rdata=0x00.
- Read with 2 wait states: slave holds pready=0 for 2 ACCESS cycles, prdata=0x3C -> penable high for 3 cycles; rsp_valid in T+5 with rsp_rdata=0x3C; paddr stable throughout.
- Slave error: read addr=0x05, pready=1 with pslverr=1 -> rsp_err=1, rsp_rdata=0x00, FSM returns to IDLE.
- Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles; psel=0 next cycle; rsp_err=1. Next command completes normally.
- Back-to-back: cmd_valid held high with two commands -> second accepted in the rsp_valid cycle; psel low for exactly 1 cycle between transfers.
- Reset mid-ACCESS: assert rst during wait state -> psel/penable 0 after that edge, no rsp_valid, cmd_ready=1 after rst deasserts.
